// File: rtl/ips2l_pcie_dma_tx_arb.sv
// Packet-level round-robin arbiter merging CplD/MRd/MWr TX streams into the PCIe core
// AXI-Stream port, with a 2-entry output skid buffer and per-source TLP counters.

module ips2l_pcie_dma_tx_arb_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // Clear beats a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

module ips2l_pcie_dma_tx_arb #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_axis_slave0_tvld,
  input  logic [DATA_WIDTH-1:0] i_axis_slave0_tdata,
  input  logic                  i_axis_slave0_tlast,
  input  logic                  i_axis_slave0_tuser,
  output logic                  o_axis_slave0_trdy,
  input  logic                  i_axis_slave1_tvld,
  input  logic [DATA_WIDTH-1:0] i_axis_slave1_tdata,
  input  logic                  i_axis_slave1_tlast,
  input  logic                  i_axis_slave1_tuser,
  output logic                  o_axis_slave1_trdy,
  input  logic                  i_axis_slave2_tvld,
  input  logic [DATA_WIDTH-1:0] i_axis_slave2_tdata,
  input  logic                  i_axis_slave2_tlast,
  input  logic                  i_axis_slave2_tuser,
  output logic                  o_axis_slave2_trdy,
  output logic                  o_axis_master_tvld,
  output logic [DATA_WIDTH-1:0] o_axis_master_tdata,
  output logic                  o_axis_master_tlast,
  output logic                  o_axis_master_tuser,
  input  logic                  i_axis_master_trdy,
  input  logic                  i_tx_restart,
  output logic [1:0]            o_grant,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt0,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt1,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt2
);
  localparam int NUM_SRC = 3;
  localparam int EW      = DATA_WIDTH + 2;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [NUM_SRC-1:0]                 src_vld, src_last, src_user, src_trdy;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0][CNT_WIDTH-1:0]  tlp_cnt;

  assign src_vld  = {i_axis_slave2_tvld,  i_axis_slave1_tvld,  i_axis_slave0_tvld};
  assign src_last = {i_axis_slave2_tlast, i_axis_slave1_tlast, i_axis_slave0_tlast};
  assign src_user = {i_axis_slave2_tuser, i_axis_slave1_tuser, i_axis_slave0_tuser};
  assign src_data = {i_axis_slave2_tdata, i_axis_slave1_tdata, i_axis_slave0_tdata};

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d, last_q, last_d;
  logic [1:0] rr_idx, winner;
  logic       found;
  logic       room_q, accept, tlp_done, push, pop;

  assign o_busy   = (state_q == BUSY);
  assign o_grant  = grant_q;
  assign accept   = o_busy && room_q && src_vld[grant_q];
  assign tlp_done = accept && src_last[grant_q];

  always_comb begin
    for (int n = 0; n < NUM_SRC; n++)
      src_trdy[n] = o_busy && room_q && (grant_q == 2'(n));
  end

  assign o_axis_slave0_trdy = src_trdy[0];
  assign o_axis_slave1_trdy = src_trdy[1];
  assign o_axis_slave2_trdy = src_trdy[2];

  // Round-robin search starting one past the previous owner.
  always_comb begin
    rr_idx = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    winner = rr_idx;
    found  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && src_vld[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
      rr_idx = (rr_idx == 2'd2) ? 2'd0 : rr_idx + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (|src_vld) begin
        state_d = BUSY;
        grant_d = winner;
        last_d  = winner;
      end
      BUSY: if (tlp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Skid buffer: {tlast, tuser, tdata}; room is registered from next occupancy
  logic [EW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    cnt_q, cnt_d;
  logic [EW-1:0] head;

  assign push = accept;
  assign pop  = o_axis_master_tvld && i_axis_master_trdy;
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  assign head  = mem[rd_ptr];

  assign o_axis_master_tvld  = (cnt_q != 2'd0);
  assign o_axis_master_tdata = o_axis_master_tvld ? head[DATA_WIDTH-1:0] : '0;
  assign o_axis_master_tuser = o_axis_master_tvld && head[DATA_WIDTH];
  assign o_axis_master_tlast = o_axis_master_tvld && head[DATA_WIDTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      room_q <= 1'b1;
    end else begin
      assert (!(push && !pop && cnt_q == 2'd2));
      cnt_q  <= cnt_d;
      room_q <= (cnt_d != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {src_last[grant_q], src_user[grant_q], src_data[grant_q]};
  end

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_cnt
    ips2l_pcie_dma_tx_arb_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (i_tx_restart),
      .inc (tlp_done && (grant_q == 2'(n))),
      .cnt (tlp_cnt[n])
    );
  end

  assign o_tlp_cnt0 = tlp_cnt[0];
  assign o_tlp_cnt1 = tlp_cnt[1];
  assign o_tlp_cnt2 = tlp_cnt[2];

endmodule

// File: tb/tb_ips2l_pcie_dma_tx_arb.sv
// Directed bench for ips2l_pcie_dma_tx_arb: queue-fed sources, output log, cycle checks.
module tb_ips2l_pcie_dma_tx_arb;
  localparam int DW = 128;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, m_trdy, restart;
  logic [2:0]    hold, has, s_vld, s_trdy;
  logic [DW+1:0] front [3];
  logic [DW+1:0] sq [3][$];
  logic          m_vld, m_last, m_user, busy;
  logic [DW-1:0] m_data;
  logic [1:0]    grant;
  logic [CW-1:0] cnt0, cnt1, cnt2;

  logic [DW-1:0] oq_d [$];
  logic          oq_l [$];
  logic          oq_u [$];
  int            oq_c [$];
  logic [1:0]    glog [$];

  int n_assert = 0, n_fail = 0;
  int cyc = 0, occ = 0, maxocc = 0, room_viol = 0;
  logic bprev = 1'b0;

  assign s_vld = has & ~hold;

  ips2l_pcie_dma_tx_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_axis_slave0_tvld(s_vld[0]), .i_axis_slave0_tdata(front[0][DW-1:0]),
    .i_axis_slave0_tlast(front[0][DW+1]), .i_axis_slave0_tuser(front[0][DW]),
    .o_axis_slave0_trdy(s_trdy[0]),
    .i_axis_slave1_tvld(s_vld[1]), .i_axis_slave1_tdata(front[1][DW-1:0]),
    .i_axis_slave1_tlast(front[1][DW+1]), .i_axis_slave1_tuser(front[1][DW]),
    .o_axis_slave1_trdy(s_trdy[1]),
    .i_axis_slave2_tvld(s_vld[2]), .i_axis_slave2_tdata(front[2][DW-1:0]),
    .i_axis_slave2_tlast(front[2][DW+1]), .i_axis_slave2_tuser(front[2][DW]),
    .o_axis_slave2_trdy(s_trdy[2]),
    .o_axis_master_tvld(m_vld), .o_axis_master_tdata(m_data),
    .o_axis_master_tlast(m_last), .o_axis_master_tuser(m_user),
    .i_axis_master_trdy(m_trdy), .i_tx_restart(restart),
    .o_grant(grant), .o_busy(busy),
    .o_tlp_cnt0(cnt0), .o_tlp_cnt1(cnt1), .o_tlp_cnt2(cnt2)
  );

  task automatic refresh();
    for (int n = 0; n < 3; n++) begin
      has[n]   = (sq[n].size() > 0);
      front[n] = has[n] ? sq[n][0] : '0;
    end
  endtask

  // Sources pop on handshake; output log, grant log and occupancy tracked here.
  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      occ   = 0;
      bprev = 1'b0;
    end else begin
      if (occ == 2 && |s_trdy) room_viol++;
      occ = occ + int'(|(s_vld & s_trdy)) - int'(m_vld & m_trdy);
      if (occ > maxocc) maxocc = occ;
      if (m_vld && m_trdy) begin
        oq_d.push_back(m_data); oq_l.push_back(m_last);
        oq_u.push_back(m_user); oq_c.push_back(cyc);
      end
      if (busy && !bprev) glog.push_back(grant);
      bprev = busy;
      for (int n = 0; n < 3; n++)
        if (s_vld[n] && s_trdy[n]) void'(sq[n].pop_front());
    end
    #1 refresh();
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat b of an nb-beat TLP: data = base+b, tuser = b[0], tlast on final beat.
  task automatic load(input int s, input int nb, input int base);
    for (int b = 0; b < nb; b++)
      sq[s].push_back({(b == nb - 1), 1'(b & 1), DW'(base + b)});
    refresh();
  endtask

  task automatic clear_logs();
    oq_d.delete(); oq_l.delete(); oq_u.delete(); oq_c.delete(); glog.delete();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (k < 200 && (sq[0].size() > 0 || sq[1].size() > 0 || sq[2].size() > 0 || busy || m_vld)) begin
      step();
      k++;
    end
    chk(tag, DW'(k < 200), DW'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_trdy"}, DW'(s_trdy), 0);
    chk({tag, "_mvld"}, DW'(m_vld), 0);
    chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_mlast"}, DW'(m_last), 0);
    chk({tag, "_muser"}, DW'(m_user), 0);
    chk({tag, "_grant"}, DW'(grant), 0);
    chk({tag, "_busy"}, DW'(busy), 0);
    chk({tag, "_cnts"}, DW'({cnt0, cnt1, cnt2}), 0);
  endtask

  initial begin
    logic [3:0] pat;
    rst = 1'b1; m_trdy = 1'b1; hold = '0; restart = 1'b0;
    refresh();
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // Single source 2, 4-beat TLP with data 1..4
    clear_logs();
    load(2, 4, 1);
    step();
    chk("t1_busy", DW'(busy), 1);
    chk("t1_grant", DW'(grant), 2);
    chk("t1_trdy", DW'(s_trdy), DW'(3'b100));
    chk("t1_first_mvld", DW'(m_vld), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t1_vld%0d", i), DW'(m_vld), 1);
      chk($sformatf("t1_data%0d", i), m_data, DW'(i + 1));
      chk($sformatf("t1_last%0d", i), DW'(m_last), DW'(i == 3));
      chk($sformatf("t1_user%0d", i), DW'(m_user), DW'(i & 1));
    end
    step();
    chk("t1_end_mvld", DW'(m_vld), 0);
    chk("t1_end_busy", DW'(busy), 0);
    chk("t1_cnt2", DW'(cnt2), 1);

    // Contention after reset: two 2-beat TLPs per source
    rst = 1'b1; step(); rst = 1'b0; step();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++) load(s, 2, s * 256 + r * 2);
    repeat (9) step();
    chk("t2_cnts_round1", DW'({cnt0, cnt1, cnt2}), DW'({4'd1, 4'd1, 4'd1}));
    chk("t2_idle_gap", DW'(busy), 0);
    drain("t2_drain");
    chk("t2_nbeats", DW'(oq_d.size()), 12);
    chk("t2_ngrants", DW'(glog.size()), 6);
    for (int i = 0; i < 12 && i < oq_d.size(); i++) begin
      chk($sformatf("t2_data%0d", i), oq_d[i], DW'(((i / 2) % 3) * 256 + (i / 6) * 2 + (i % 2)));
      chk($sformatf("t2_last%0d", i), DW'(oq_l[i]), DW'(i % 2));
      if (i > 0) chk($sformatf("t2_gap%0d", i), DW'(oq_c[i] - oq_c[i-1]), DW'((i % 2) ? 1 : 2));
    end
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk($sformatf("t2_grant%0d", i), DW'(glog[i]), DW'(i % 3));
    chk("t2_cnts", DW'({cnt0, cnt1, cnt2}), DW'({4'd2, 4'd2, 4'd2}));

    // Core back-pressure 1,0,0,1 on an 8-beat MWr TLP
    clear_logs();
    maxocc = 0;
    pat = 4'b1001;
    load(2, 8, 2 * 256 + 16);
    for (int k = 0; k < 100 && (sq[2].size() > 0 || busy || m_vld); k++) begin
      m_trdy = pat[k % 4];
      step();
    end
    m_trdy = 1'b1;
    chk("t3_nbeats", DW'(oq_d.size()), 8);
    for (int i = 0; i < 8 && i < oq_d.size(); i++) begin
      chk($sformatf("t3_data%0d", i), oq_d[i], DW'(2 * 256 + 16 + i));
      chk($sformatf("t3_last%0d", i), DW'(oq_l[i]), DW'(i == 7));
    end
    chk("t3_maxocc", DW'(maxocc), 2);
    chk("t3_room_viol", DW'(room_viol), 0);
    chk("t3_ngrants", DW'(glog.size()), 1);
    chk("t3_cnt2", DW'(cnt2), 3);

    // Source 1 stalls 3 cycles mid-TLP while source 0 waits
    clear_logs();
    load(1, 4, 256 + 32);
    step();
    chk("t4_grant1", DW'(grant), 1);
    load(0, 1, 32);
    step(); step();
    hold[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_hold_grant%0d", i), DW'(grant), 1);
      chk($sformatf("t4_hold_trdy0_%0d", i), DW'(s_trdy[0]), 0);
      chk($sformatf("t4_hold_mvld%0d", i), DW'(m_vld), 0);
    end
    hold[1] = 1'b0;
    drain("t4_drain");
    chk("t4_nbeats", DW'(oq_d.size()), 5);
    for (int i = 0; i < 5 && i < oq_d.size(); i++)
      chk($sformatf("t4_data%0d", i), oq_d[i], DW'((i < 4) ? 256 + 32 + i : 32));
    chk("t4_ngrants", DW'(glog.size()), 2);
    if (glog.size() == 2) chk("t4_grant_after", DW'(glog[1]), 0);
    chk("t4_cnts", DW'({cnt0, cnt1, cnt2}), DW'({4'd3, 4'd3, 4'd3}));

    // Restart alone, wrap, restart coincident with tlast
    restart = 1'b1; step(); restart = 1'b0;
    chk("t5_restart", DW'({cnt0, cnt1, cnt2}), 0);
    for (int i = 0; i < 15; i++) load(0, 1, 64 + i);
    drain("t5_drain15");
    chk("t5_cnt0_max", DW'(cnt0), 15);
    load(0, 1, 80);
    drain("t5_drain_wrap");
    chk("t5_cnt0_wrap", DW'(cnt0), 0);
    load(0, 1, 81);
    drain("t5_drain_one");
    chk("t5_cnt0_one", DW'(cnt0), 1);
    load(0, 1, 82);
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t5_restart_wins", DW'(cnt0), 0);
    drain("t5_drain_end");

    // Reset on beat 2 of a source-1 TLP
    load(1, 4, 256 + 48);
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk_reset_vals("t6");
    for (int n = 0; n < 3; n++) sq[n].delete();
    refresh();
    step();
    rst = 1'b0;
    clear_logs();
    for (int s = 0; s < 3; s++) load(s, 1, s * 256 + 96);
    step();
    chk("t6_first_grant", DW'(grant), 0);
    chk("t6_busy", DW'(busy), 1);
    drain("t6_drain");
    chk("t6_nbeats", DW'(oq_d.size()), 3);
    for (int i = 0; i < 3 && i < oq_d.size(); i++)
      chk($sformatf("t6_data%0d", i), oq_d[i], DW'(i * 256 + 96));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
